// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the mem_ctrl RAM front end.
//   state_e     : controller FSM states
//   DefTimeout  : default bound on cycles spent waiting for the RAM handshake
//   DefSettle   : default number of cycles req_ready stays low after reset
package mem_ctrl_pkg;

    localparam int unsigned DefTimeout = 16;
    localparam int unsigned DefSettle  = 2;

    typedef enum logic [2:0] {
        StSettle,
        StIdle,
        StWaitLo,
        StWaitHi,
        StResp
    } state_e;

    function automatic logic is_wait_state(state_e s);
        return (s == StWaitLo) || (s == StWaitHi);
    endfunction

endpackage

// File: rtl/mem_ctrl_wdog.sv
// Watchdog counter for the RAM handshake.
//   clk_i      : clock
//   rst_ni     : synchronous reset, active low
//   clr_i      : restart the count (wins over en_i)
//   en_i       : count this cycle
//   expired_o  : high while counting in the Limit-th cycle since the last clear
module mem_ctrl_wdog #(
    parameter int unsigned Limit = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned     CntW    = $clog2(Limit + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter saturates at the last value so expired_o stays asserted while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mem_ctrl.sv
// Request/response front end for a change-detect word RAM. It is the only RAM driver.
// The RAM starts an access only when ram_data/ram_wr change, drops ram_response to signal the
// start and raises it again on completion. Every CPU request is turned into a visible change.
//   clk_i, rst_ni               : clock, synchronous active-low reset
//   req_valid_i / req_ready_o   : CPU request handshake (accept when both high)
//   req_wr_i, req_addr_i, req_data_i : access kind, word address, write data
//   resp_valid_o                : one-cycle completion pulse
//   resp_data_o, resp_err_o     : read data (0 for writes/aborts), timeout flag
//   ram_data_o, ram_addr_o, ram_wr_o : registered RAM drive, stable for a whole access
//   ram_response_i, ram_out_i   : RAM handshake and read data
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned AddrW   = 32,
    parameter int unsigned DataW   = 32,
    parameter int unsigned Timeout = DefTimeout,
    parameter int unsigned Settle  = DefSettle   // must be >= 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_wr_i,
    input  logic [AddrW-1:0] req_addr_i,
    input  logic [DataW-1:0] req_data_i,
    output logic             resp_valid_o,
    output logic [DataW-1:0] resp_data_o,
    output logic             resp_err_o,
    output logic [DataW-1:0] ram_data_o,
    output logic [AddrW-1:0] ram_addr_o,
    output logic             ram_wr_o,
    input  logic             ram_response_i,
    input  logic [DataW-1:0] ram_out_i
);

    localparam int unsigned        SettleW    = $clog2(Settle + 1);
    localparam logic [SettleW-1:0] LastSettle = SettleW'(Settle - 1);

    state_e             state_q, state_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic               kick_q, kick_d;
    logic               lat_wr_q, lat_wr_d;
    logic [DataW-1:0]   lat_data_q, lat_data_d;
    // The registered RAM drive doubles as the last_data/last_wr shadow: it only ever
    // changes on an issue, so it always holds what the RAM last saw from us.
    logic [DataW-1:0]   ram_data_q, ram_data_d;
    logic [AddrW-1:0]   ram_addr_q, ram_addr_d;
    logic               ram_wr_q, ram_wr_d;
    logic [DataW-1:0]   rd_data_q, rd_data_d;
    logic               err_q, err_d;

    logic wdog_clr, wdog_en, wdog_expired;

    assign wdog_en  = is_wait_state(state_q);
    // Any entry into WaitLo restarts the watchdog, including the re-issue after a kick.
    assign wdog_clr = (state_d == StWaitLo) && (state_q != StWaitLo);

    mem_ctrl_wdog #(
        .Limit(Timeout)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (wdog_clr),
        .en_i     (wdog_en),
        .expired_o(wdog_expired)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StSettle;
            settle_q   <= '0;
            kick_q     <= 1'b0;
            lat_wr_q   <= 1'b0;
            lat_data_q <= '0;
            ram_data_q <= '0;
            ram_addr_q <= '0;
            ram_wr_q   <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            kick_q     <= kick_d;
            lat_wr_q   <= lat_wr_d;
            lat_data_q <= lat_data_d;
            ram_data_q <= ram_data_d;
            ram_addr_q <= ram_addr_d;
            ram_wr_q   <= ram_wr_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        kick_d     = kick_q;
        lat_wr_d   = lat_wr_q;
        lat_data_d = lat_data_q;
        ram_data_d = ram_data_q;
        ram_addr_d = ram_addr_q;
        ram_wr_d   = ram_wr_q;
        rd_data_d  = rd_data_q;
        err_d      = err_q;

        unique case (state_q)
            StSettle: begin
                if (settle_q == LastSettle) begin
                    state_d = StIdle;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end

            StIdle: begin
                if (req_valid_i) begin
                    lat_wr_d   = req_wr_i;
                    lat_data_d = req_data_i;
                    ram_addr_d = req_addr_i;
                    rd_data_d  = '0;
                    err_d      = 1'b0;
                    state_d    = StWaitLo;
                    if (req_wr_i && ram_wr_q && (req_data_i == ram_data_q)) begin
                        // An identical repeat write is invisible to the RAM. Issue a dummy
                        // read straight away (the kick) so the write costs only one extra
                        // RAM round trip.
                        kick_d     = 1'b1;
                        ram_wr_d   = 1'b0;
                        ram_data_d = ~ram_data_q;
                    end else begin
                        // Reads drive inverted data so the RAM always sees a change.
                        ram_wr_d   = req_wr_i;
                        ram_data_d = req_wr_i ? req_data_i : ~ram_data_q;
                    end
                end
            end

            StWaitLo: begin
                if (wdog_expired) begin
                    state_d   = StResp;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    kick_d    = 1'b0;
                end else if (!ram_response_i) begin
                    state_d = StWaitHi;
                end
            end

            StWaitHi: begin
                if (wdog_expired) begin
                    state_d   = StResp;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    kick_d    = 1'b0;
                end else if (ram_response_i) begin
                    if (kick_q) begin
                        kick_d     = 1'b0;
                        ram_wr_d   = lat_wr_q;
                        ram_data_d = lat_data_q;
                        state_d    = StWaitLo;
                    end else begin
                        rd_data_d = lat_wr_q ? '0 : ram_out_i;
                        state_d   = StResp;
                    end
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StSettle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        req_ready_o  = (state_q == StIdle);
        resp_valid_o = (state_q == StResp);
        resp_data_o  = rd_data_q;
        resp_err_o   = err_q;
        ram_data_o   = ram_data_q;
        ram_addr_o   = ram_addr_q;
        ram_wr_o     = ram_wr_q;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a behavioural change-detect RAM (1024 words).
module tb_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] ram_data;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic        ram_response;
    logic [31:0] ram_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int resp_cnt = 0;
    int acc_edge = 0;

    mem_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_wr_i      (req_wr),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .resp_valid_o  (resp_valid),
        .resp_data_o   (resp_data),
        .resp_err_o    (resp_err),
        .ram_data_o    (ram_data),
        .ram_addr_o    (ram_addr),
        .ram_wr_o      (ram_wr),
        .ram_response_i(ram_response),
        .ram_out_i     (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- change-detect RAM ----------------
    logic [31:0] ram_mem [1024];
    logic        ram_resp_q  = 1'b1;
    logic [31:0] ram_prev_d  = 32'h0;
    logic        ram_prev_w  = 1'b0;
    logic [31:0] ram_out_q   = 32'h0;
    logic        force_hi    = 1'b0;

    always @(negedge clk) begin
        if (!ram_resp_q) begin
            if (ram_wr) ram_mem[ram_addr[9:0]] <= ram_data;
            else        ram_out_q <= ram_mem[ram_addr[9:0]];
            ram_resp_q <= 1'b1;
        end else if ((ram_data != ram_prev_d) || (ram_wr != ram_prev_w)) begin
            ram_prev_d <= ram_data;
            ram_prev_w <= ram_wr;
            ram_resp_q <= 1'b0;
        end
    end

    assign ram_response = force_hi ? 1'b1 : ram_resp_q;
    assign ram_out      = ram_out_q;

    // ---------------- reference model ----------------
    // Memory wraps modulo 1024; a write that repeats the previous access (a write of the same
    // data) needs a kick and costs 2 extra cycles. Base latency is 2 edges.
    logic [31:0] mdl_mem [1024];
    logic        mdl_prev_wr   = 1'b0;
    logic [31:0] mdl_prev_data = 32'h0;

    function automatic void mdl_access(input logic wr, input logic [31:0] addr,
                                       input logic [31:0] data,
                                       output logic [31:0] exp_rd, output int exp_lat);
        exp_lat = (wr && mdl_prev_wr && (data == mdl_prev_data)) ? 4 : 2;
        exp_rd  = wr ? 32'h0 : mdl_mem[addr % 1024];
        if (wr) mdl_mem[addr % 1024] = data;
        mdl_prev_wr   = wr;
        mdl_prev_data = data;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input bit hold);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_data  = data;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc_edge = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] rd, output logic err, output int lat);
        int t = 0;
        @(negedge clk);
        while (!resp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("resp_seen", {31'b0, resp_valid}, 32'd1);
        rd  = resp_data;
        err = resp_err;
        lat = cyc - acc_edge;
    endtask

    // A response must never coincide with readiness for a new request.
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            checks++;
            if (req_ready) begin
                failures++;
                $display("FAIL ready_during_resp: req_ready=1 required 0 (t=%0t)", $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] ram_snap [9];

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic        err;
        int          lat;
        int          exp_lat;
        int          base;

        vecs[0] = '{1'b1, 32'd5, 32'hDEADBEEF, 32'h0,        2};
        vecs[1] = '{1'b0, 32'd5, 32'h0,        32'hDEADBEEF, 2};
        vecs[2] = '{1'b1, 32'd7, 32'h1234,     32'h0,        2};
        vecs[3] = '{1'b1, 32'd9, 32'h1234,     32'h0,        4};
        vecs[4] = '{1'b0, 32'd9, 32'h0,        32'h1234,     2};
        vecs[5] = '{1'b0, 32'd7, 32'h0,        32'h1234,     2};
        vecs[6] = '{1'b1, 32'd3, 32'hA5A5A5A5, 32'h0,        2};
        vecs[7] = '{1'b0, 32'd3, 32'h0,        32'hA5A5A5A5, 2};
        vecs[8] = '{1'b0, 32'd3, 32'h0,        32'hA5A5A5A5, 2};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",      {31'b0, req_ready},  32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data",  resp_data,           32'd0);
        check("rst_resp_err",   {31'b0, resp_err},   32'd0);
        check("rst_ram_data",   ram_data,            32'd0);
        check("rst_ram_addr",   ram_addr,            32'd0);
        check("rst_ram_wr",     {31'b0, ram_wr},     32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk) check("settle_ready_0", {31'b0, req_ready}, 32'd0);
        @(negedge clk) check("settle_ready_1", {31'b0, req_ready}, 32'd0);
        @(negedge clk) check("settle_ready_2", {31'b0, req_ready}, 32'd1);

        // ---- table: write/read, kick path, back-to-back reads ----
        for (int i = 0; i < 9; i++) begin
            mdl_access(vecs[i].wr, vecs[i].addr, vecs[i].data, exp_rd, exp_lat);
            send(vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0);
            get_resp(rd, err, lat);
            ram_snap[i] = ram_data;
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, err}, 32'd0);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end
        check("read_issue_inverted", ram_snap[7], 32'h5A5A5A5A);
        check("read_issue_restored", ram_snap[8], 32'hA5A5A5A5);

        // ---- timeout: RAM handshake hidden ----
        force_hi = 1'b1;
        mdl_access(1'b0, 32'd5, 32'h0, exp_rd, exp_lat);
        send(1'b0, 32'd5, 32'h0, 1'b0);
        get_resp(rd, err, lat);
        check("tmo_lat",  32'(lat),       32'd16);
        check("tmo_err",  {31'b0, err},   32'd1);
        check("tmo_data", rd,             32'd0);
        force_hi = 1'b0;
        mdl_access(1'b0, 32'd5, 32'h0, exp_rd, exp_lat);
        send(1'b0, 32'd5, 32'h0, 1'b0);
        get_resp(rd, err, lat);
        check("post_tmo_data", rd,           exp_rd);
        check("post_tmo_err",  {31'b0, err}, 32'd0);
        check("post_tmo_lat",  32'(lat),     32'(exp_lat));

        // ---- reset during WaitHi abandons the access ----
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'd9;
        check("mid_rst_idle_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        base = resp_cnt;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mdl_prev_wr = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_0", {31'b0, req_ready}, 32'd0);
        check("mid_rst_ram_wr",  {31'b0, ram_wr},    32'd0);
        check("mid_rst_ram_data", ram_data,          32'd0);
        @(negedge clk) check("mid_rst_ready_1", {31'b0, req_ready}, 32'd0);
        @(negedge clk) check("mid_rst_ready_2", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 check("mid_rst_no_resp", 32'(resp_cnt - base), 32'd0);
        mdl_access(1'b0, 32'd5, 32'h0, exp_rd, exp_lat);
        send(1'b0, 32'd5, 32'h0, 1'b0);
        get_resp(rd, err, lat);
        check("post_rst_data", rd,       32'hDEADBEEF);
        check("post_rst_lat",  32'(lat), 32'd2);

        // ---- wrap and req_valid held across RESP ----
        mdl_access(1'b1, 32'd1029, 32'h55, exp_rd, exp_lat);
        send(1'b1, 32'd1029, 32'h55, 1'b1);
        get_resp(rd, err, lat);
        check("wrap_wr_lat", 32'(lat), 32'(exp_lat));
        check("hold_ready_in_resp", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("hold_ready_in_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc_edge  = cyc;
        req_valid = 1'b0;
        mdl_access(1'b1, 32'd1029, 32'h55, exp_rd, exp_lat);
        get_resp(rd, err, lat);
        check("hold_reaccept_lat", 32'(lat), 32'd4);
        check("hold_reaccept_err", {31'b0, err}, 32'd0);
        mdl_access(1'b0, 32'd1029, 32'h0, exp_rd, exp_lat);
        send(1'b0, 32'd1029, 32'h0, 1'b0);
        get_resp(rd, err, lat);
        check("wrap_rd_1029", rd, 32'h55);
        mdl_access(1'b0, 32'd5, 32'h0, exp_rd, exp_lat);
        send(1'b0, 32'd5, 32'h0, 1'b0);
        get_resp(rd, err, lat);
        check("wrap_rd_5", rd, 32'h55);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 56; i++) begin
            logic        wr;
            logic [31:0] addr;
            logic [31:0] data;
            int          sel;
            addr = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) addr = addr + 32'd1024;
            sel  = $urandom_range(0, 3);
            data = (sel == 0) ? 32'h1111 : (sel == 1) ? 32'h2222 : $urandom;
            // The first 16 operations write every address before any random read.
            if (i < 16) begin
                wr   = 1'b1;
                addr = (addr & 32'hFFFF_FC00) | 32'(i);
            end else begin
                wr = 1'($urandom_range(0, 1));
            end
            mdl_access(wr, addr, data, exp_rd, exp_lat);
            send(wr, addr, data, 1'b0);
            get_resp(rd, err, lat);
            check($sformatf("rnd%0d_data", i), rd, exp_rd);
            check($sformatf("rnd%0d_err", i), {31'b0, err}, 32'd0);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
